// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS clocking-path reset sequencer:
// the sequencer state encoding, default timing constants and small helpers.
package tmds_pkg;

    typedef enum logic [1:0] {
        RESET_PLL   = 2'd0,
        WAIT_LOCK   = 2'd1,
        RELEASE_SER = 2'd2,
        RUN         = 2'd3
    } state_t;

    localparam int DEF_PLL_RST_CYC      = 16;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYC = 65535;
    localparam int DEF_SER_TO_PIX_CYC   = 8;
    localparam int DEF_LOSS_FILT_CYC    = 4;
    localparam int DEF_CNT_W            = 8;

    // Larger of two integers, used to size shared counters.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reset/ready levels for a state, packed as {pll_rst, ser_rst, pix_rst, ready}.
    function automatic logic [3:0] state_outs(input state_t s);
        case (s)
            RESET_PLL:   return 4'b1110;
            WAIT_LOCK:   return 4'b0110;
            RELEASE_SER: return 4'b0010;
            RUN:         return 4'b0001;
            default:     return 4'b1110;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Reusable for any slow asynchronous status input (PLL lock, etc.).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Two back-to-back flops give metastability a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/tmds_pll_rst_seq.sv
// Reset sequencer for the TMDS PLL: pulses PLL reset, waits for a stable
// lock, releases the serializer domain then the pixel domain, and
// re-sequences on filtered lock loss or lock timeout.
// Optional status counters are built when TMDS_RSTSEQ_STATUS_EN is defined;
// otherwise O_loss_cnt / O_retry_cnt are tied to zero.
module tmds_pll_rst_seq
    import tmds_pkg::*;
#(
    parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int SER_TO_PIX_CYC   = DEF_SER_TO_PIX_CYC,
    parameter int LOSS_FILT_CYC    = DEF_LOSS_FILT_CYC,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_pll_lock,
    output logic             O_pll_rst,
    output logic             O_ser_rst,
    output logic             O_pix_rst,
    output logic             O_ready,
    output logic [1:0]       O_state,
    output logic [CNT_W-1:0] O_loss_cnt,
    output logic [CNT_W-1:0] O_retry_cnt
);

    // Phase counter covers PLL reset dwell, lock timeout and ser->pix delay;
    // filter counter covers lock-stable and lock-loss runs. Only one use of
    // each is live in any state, and both clear on every state entry.
    localparam int PH_W = $clog2(max2(max2(PLL_RST_CYC, LOCK_TIMEOUT_CYC), SER_TO_PIX_CYC) + 1);
    localparam int FL_W = $clog2(max2(LOCK_STABLE_CYC, LOSS_FILT_CYC) + 1);

    localparam logic [PH_W-1:0] PLL_LAST    = PH_W'(PLL_RST_CYC - 1);
    localparam logic [PH_W-1:0] TMO_LAST    = PH_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [PH_W-1:0] S2P_LAST    = PH_W'(SER_TO_PIX_CYC - 1);
    localparam logic [FL_W-1:0] STABLE_DONE = FL_W'(LOCK_STABLE_CYC);
    localparam logic [FL_W-1:0] LOSS_DONE   = FL_W'(LOSS_FILT_CYC);

    logic            lock_s;
    state_t          state_reg;
    state_t          state_next;
    logic [PH_W-1:0] ph_cnt_reg;
    logic [FL_W-1:0] fl_cnt_reg;
    logic            pll_rst_reg;
    logic            ser_rst_reg;
    logic            pix_rst_reg;
    logic            ready_reg;
    logic            retry_evt;
    logic            loss_evt;

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clk (I_clk),
        .rst (I_rst),
        .d   (I_pll_lock),
        .q   (lock_s)
    );

    // Next-state decision; success beats timeout, loss beats release to RUN.
    always_comb begin
        state_next = state_reg;
        retry_evt  = 1'b0;
        loss_evt   = 1'b0;
        case (state_reg)
            RESET_PLL: begin
                if (ph_cnt_reg == PLL_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (fl_cnt_reg >= STABLE_DONE) begin
                    state_next = RELEASE_SER;
                end else if (ph_cnt_reg == TMO_LAST) begin
                    state_next = RESET_PLL;
                    retry_evt  = 1'b1;
                end
            end
            RELEASE_SER: begin
                if (fl_cnt_reg >= LOSS_DONE) begin
                    state_next = RESET_PLL;
                    loss_evt   = 1'b1;
                end else if (ph_cnt_reg == S2P_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (fl_cnt_reg >= LOSS_DONE) begin
                    state_next = RESET_PLL;
                    loss_evt   = 1'b1;
                end
            end
            default: state_next = RESET_PLL;
        endcase
    end

    // Sequencer state, counters and registered outputs decoded from the next state.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_reg   <= RESET_PLL;
            ph_cnt_reg  <= '0;
            fl_cnt_reg  <= '0;
            pll_rst_reg <= 1'b1;
            ser_rst_reg <= 1'b1;
            pix_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            {pll_rst_reg, ser_rst_reg, pix_rst_reg, ready_reg} <= state_outs(state_next);
            if (state_next != state_reg) begin
                ph_cnt_reg <= '0;
                fl_cnt_reg <= '0;
            end else begin
                if (state_reg != RUN) ph_cnt_reg <= ph_cnt_reg + 1'b1;
                case (state_reg)
                    WAIT_LOCK:        fl_cnt_reg <= lock_s ? fl_cnt_reg + 1'b1 : '0;
                    RELEASE_SER, RUN: fl_cnt_reg <= lock_s ? '0 : fl_cnt_reg + 1'b1;
                    default:          fl_cnt_reg <= '0;
                endcase
            end
        end
    end

    assign O_pll_rst = pll_rst_reg;
    assign O_ser_rst = ser_rst_reg;
    assign O_pix_rst = pix_rst_reg;
    assign O_ready   = ready_reg;
    assign O_state   = state_reg;

`ifdef TMDS_RSTSEQ_STATUS_EN
    logic [CNT_W-1:0] loss_cnt_reg;
    logic [CNT_W-1:0] retry_cnt_reg;

    // Saturating event counters; only the external reset clears them.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            loss_cnt_reg  <= '0;
            retry_cnt_reg <= '0;
        end else begin
            if (loss_evt && (loss_cnt_reg != '1))   loss_cnt_reg  <= loss_cnt_reg + 1'b1;
            if (retry_evt && (retry_cnt_reg != '1)) retry_cnt_reg <= retry_cnt_reg + 1'b1;
        end
    end

    assign O_loss_cnt  = loss_cnt_reg;
    assign O_retry_cnt = retry_cnt_reg;
`else
    logic unused_evt;
    assign unused_evt  = loss_evt ^ retry_evt;
    assign O_loss_cnt  = '0;
    assign O_retry_cnt = '0;
`endif

endmodule

// File: tb/tb_tmds_pll_rst_seq.sv
// Testbench for tmds_pll_rst_seq with small timing parameters.
// Expected counter values follow TMDS_RSTSEQ_STATUS_EN (zero when undefined).
module tb_tmds_pll_rst_seq;

    localparam int CNT_W = 8;
`ifdef TMDS_RSTSEQ_STATUS_EN
    localparam bit ST_EN = 1'b1;
`else
    localparam bit ST_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lock = 1'b0;
    logic             pll_rst, ser_rst, pix_rst, ready;
    logic [1:0]       state;
    logic [CNT_W-1:0] loss_cnt, retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         lat;
        logic [5:0] vec;
        logic [7:0] loss;
        logic [7:0] retry;
    } exp_t;
    exp_t exp_q[$];

    tmds_pll_rst_seq #(
        .PLL_RST_CYC      (4),
        .LOCK_STABLE_CYC  (8),
        .LOCK_TIMEOUT_CYC (40),
        .SER_TO_PIX_CYC   (3),
        .LOSS_FILT_CYC    (2),
        .CNT_W            (CNT_W)
    ) dut (
        .I_clk       (clk),
        .I_rst       (rst),
        .I_pll_lock  (lock),
        .O_pll_rst   (pll_rst),
        .O_ser_rst   (ser_rst),
        .O_pix_rst   (pix_rst),
        .O_ready     (ready),
        .O_state     (state),
        .O_loss_cnt  (loss_cnt),
        .O_retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    // Packed {pll_rst, ser_rst, pix_rst, ready, state}
    function automatic logic [5:0] obs();
        return {pll_rst, ser_rst, pix_rst, ready, state};
    endfunction

    function automatic logic [7:0] st(input int v);
        return ST_EN ? 8'(v) : 8'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst  = 1'b1;
        lock = 1'b0;
        repeat (3) step();
        n_checks++;
        if (obs() !== 6'b111000 || loss_cnt !== 8'd0 || retry_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_hold: outs=%b loss=%0d retry=%0d, need outs=111000 loss=0 retry=0", obs(), loss_cnt, retry_cnt);
        end
        for (int k = 1; k <= 4; k++)
            exp_q.push_back('{k, (k < 4) ? 6'b111000 : 6'b011001, 8'd0, 8'd0});
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e.vec) begin
                n_fail++;
                $display("FAIL pll_pulse edge %0d: outs=%b need %b", e.lat, obs(), e.vec);
            end
            $display("txn pll_pulse edge=%0d outs=%b", e.lat, obs());
        end
    endtask

    task automatic test_lock_release();
        exp_t e;
        int   n;
        repeat (10) step();
        lock = 1'b1;
        exp_q.push_back('{10, 6'b001010, 8'd0, 8'd0});
        exp_q.push_back('{3,  6'b000111, 8'd0, 8'd0});
        n = 0;
        do begin step(); n++; end while (ser_rst !== 1'b0 && n < 50);
        e = exp_q.pop_front();
        n_checks++;
        if ((n - 1) !== e.lat || obs() !== e.vec) begin
            n_fail++;
            $display("FAIL ser_release: lat=%0d outs=%b, need lat=%0d outs=%b", n - 1, obs(), e.lat, e.vec);
        end
        $display("txn ser_release lat=%0d outs=%b", n - 1, obs());
        n = 0;
        do begin step(); n++; end while (pix_rst !== 1'b0 && n < 20);
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e.lat || obs() !== e.vec) begin
            n_fail++;
            $display("FAIL pix_release: lat=%0d outs=%b, need lat=%0d outs=%b", n, obs(), e.lat, e.vec);
        end
        $display("txn pix_release lat=%0d outs=%b", n, obs());
    endtask

    task automatic test_glitch();
        exp_t e;
        int   bad = 0;
        exp_q.push_back('{0, 6'b000111, 8'd0, 8'd0});
        lock = 1'b0;
        step();
        lock = 1'b1;
        repeat (8) begin
            step();
            if (obs() !== 6'b000111) bad++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (bad !== e.lat || loss_cnt !== e.loss) begin
            n_fail++;
            $display("FAIL glitch: bad_cycles=%0d loss=%0d, need bad_cycles=0 loss=%0d", bad, loss_cnt, e.loss);
        end
        $display("txn glitch bad_cycles=%0d", bad);
    endtask

    task automatic test_loss();
        exp_t e;
        int   n;
        exp_q.push_back('{4, 6'b111000, st(1), 8'd0});
        lock = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            if (n == 3) lock = 1'b1;
        end while (ready !== 1'b0 && n < 20);
        e = exp_q.pop_front();
        n_checks++;
        if ((n - 1) !== e.lat || obs() !== e.vec || loss_cnt !== e.loss || retry_cnt !== e.retry) begin
            n_fail++;
            $display("FAIL lock_loss: lat=%0d outs=%b loss=%0d retry=%0d, need lat=%0d outs=%b loss=%0d retry=%0d",
                     n - 1, obs(), loss_cnt, retry_cnt, e.lat, e.vec, e.loss, e.retry);
        end
        $display("txn lock_loss lat=%0d outs=%b loss=%0d", n - 1, obs(), loss_cnt);
        n = 0;
        do begin step(); n++; end while (state !== 2'd3 && n < 100);
        n_checks++;
        if (state !== 2'd3) begin
            n_fail++;
            $display("FAIL resequence: state=%0d need 3", state);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n;
        lock = 1'b0;
        n = 0;
        do begin step(); n++; end while (state !== 2'd1 && n < 50);
        exp_q.push_back('{40, 6'b111000, st(2), st(1)});
        exp_q.push_back('{4,  6'b011001, st(2), st(1)});
        n = 0;
        do begin step(); n++; end while (state === 2'd1 && n < 100);
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e.lat || obs() !== e.vec || loss_cnt !== e.loss || retry_cnt !== e.retry) begin
            n_fail++;
            $display("FAIL timeout: dwell=%0d outs=%b loss=%0d retry=%0d, need dwell=%0d outs=%b loss=%0d retry=%0d",
                     n, obs(), loss_cnt, retry_cnt, e.lat, e.vec, e.loss, e.retry);
        end
        $display("txn timeout dwell=%0d retry=%0d", n, retry_cnt);
        n = 0;
        do begin step(); n++; end while (state !== 2'd1 && n < 20);
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e.lat || obs() !== e.vec) begin
            n_fail++;
            $display("FAIL retry_pulse: len=%0d outs=%b, need len=%0d outs=%b", n, obs(), e.lat, e.vec);
        end
        $display("txn retry_pulse len=%0d", n);
    endtask

    task automatic test_retry_sat();
        exp_t       e;
        int         n;
        logic [1:0] prev;
        exp_q.push_back('{299, 6'b111000, st(2), st(255)});
        for (int i = 0; i < 299; i++) begin
            n = 0;
            do begin prev = state; step(); n++; end while (!(prev == 2'd1 && state == 2'd0) && n < 100);
            if (n >= 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL retry_loop: no timeout within bound at iter %0d", i);
                break;
            end
        end
        e = exp_q.pop_front();
        n_checks++;
        if (retry_cnt !== e.retry || loss_cnt !== e.loss || obs() !== e.vec) begin
            n_fail++;
            $display("FAIL retry_sat: retry=%0d loss=%0d outs=%b, need retry=%0d loss=%0d outs=%b",
                     retry_cnt, loss_cnt, obs(), e.retry, e.loss, e.vec);
        end
        $display("txn retry_sat retry=%0d", retry_cnt);
    endtask

    task automatic test_toggle();
        exp_t e;
        int   n;
        bit   hit2 = 1'b0;
        n = 0;
        do begin step(); n++; end while (state !== 2'd1 && n < 20);
        exp_q.push_back('{40, 6'b111000, st(2), st(255)});
        n = 0;
        do begin
            lock = ~lock;
            step();
            n++;
            if (state === 2'd2) hit2 = 1'b1;
        end while (state === 2'd1 && n < 100);
        lock = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (hit2 || n !== e.lat || obs() !== e.vec || retry_cnt !== e.retry) begin
            n_fail++;
            $display("FAIL toggle: reached2=%0d dwell=%0d outs=%b retry=%0d, need reached2=0 dwell=%0d outs=%b retry=%0d",
                     hit2, n, obs(), retry_cnt, e.lat, e.vec, e.retry);
        end
        $display("txn toggle dwell=%0d reached2=%0d", n, hit2);
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   n;
        lock = 1'b1;
        n = 0;
        do begin step(); n++; end while (state !== 2'd2 && n < 100);
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL reach_release_ser: state=%0d need 2", state);
        end
        exp_q.push_back('{0, 6'b111000, 8'd0, 8'd0});
        #3;
        rst = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e.vec || loss_cnt !== e.loss || retry_cnt !== e.retry) begin
            n_fail++;
            $display("FAIL async_reset: outs=%b loss=%0d retry=%0d, need outs=%b loss=0 retry=0", obs(), loss_cnt, retry_cnt, e.vec);
        end
        $display("txn async_reset outs=%b", obs());
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++;
        if (obs() !== 6'b111000) begin
            n_fail++;
            $display("FAIL restart: outs=%b need 111000", obs());
        end
        n = 0;
        do begin step(); n++; end while (state !== 2'd3 && n < 100);
        n_checks++;
        if (state !== 2'd3 || obs() !== 6'b000111 || loss_cnt !== 8'd0 || retry_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rerun: outs=%b loss=%0d retry=%0d, need outs=000111 loss=0 retry=0", obs(), loss_cnt, retry_cnt);
        end
        $display("txn rerun outs=%b", obs());
    endtask

    initial begin
        test_reset();
        test_lock_release();
        test_glitch();
        test_loss();
        test_timeout();
        test_retry_sat();
        test_toggle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
